// File: rtl/logic_unit_if.sv
// Handshake bundle between an operand source, the logic unit and a result consumer.
// The slave side is the logic unit; the master side is the source/consumer pair.
interface logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_parity;
  logic [15:0]      ops_done;

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_parity, ops_done
  );

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_parity, ops_done
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit: eight selectable ops on two operands, with zero/parity flags,
// delivered through a small FIFO result buffer with valid/ready on both sides.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  logic_unit_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = WIDTH + 2;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUFA = 3'd7
  } op_e;

  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [WIDTH-1:0] r_last_y;
  logic             r_last_zero;
  logic             r_last_parity;
  logic [15:0]      r_ops_done;

  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_parity;
  logic [EW-1:0]    w_entry;
  logic [EW-1:0]    w_head;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wptr_next;
  logic [PW-1:0]    w_rptr_next;

  always_comb begin
    w_result = '0;
    case (op_e'(bus.in_op))
      OP_AND:  w_result = bus.in_a & bus.in_b;
      OP_OR:   w_result = bus.in_a | bus.in_b;
      OP_NOTA: w_result = ~bus.in_a;
      OP_NAND: w_result = ~(bus.in_a & bus.in_b);
      OP_NOR:  w_result = ~(bus.in_a | bus.in_b);
      OP_XOR:  w_result = bus.in_a ^ bus.in_b;
      OP_XNOR: w_result = ~(bus.in_a ^ bus.in_b);
      OP_BUFA: w_result = bus.in_a;
      default: w_result = '0;
    endcase
  end

  assign w_zero   = ~|w_result;
  assign w_parity = ^w_result;
  assign w_entry  = {w_parity, w_zero, w_result};

  // Ready comes only from the registered count, so a pop on a full buffer
  // cannot admit a push in the same cycle.
  assign w_in_ready  = (r_count < CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  assign w_wptr_next = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_next = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  assign w_head = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= w_wptr_next;
      if (w_pop)  r_rptr <= w_rptr_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The popped entry is kept so an empty buffer still presents the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_y      <= '0;
      r_last_zero   <= 1'b0;
      r_last_parity <= 1'b0;
      r_ops_done    <= '0;
    end else if (w_pop) begin
      r_last_y      <= w_head[WIDTH-1:0];
      r_last_zero   <= w_head[WIDTH];
      r_last_parity <= w_head[WIDTH+1];
      if (r_ops_done != 16'hFFFF) begin
        r_ops_done <= r_ops_done + 16'd1;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_y      = w_out_valid ? w_head[WIDTH-1:0] : r_last_y;
  assign bus.out_zero   = w_out_valid ? w_head[WIDTH]     : r_last_zero;
  assign bus.out_parity = w_out_valid ? w_head[WIDTH+1]   : r_last_parity;
  assign bus.ops_done   = r_ops_done;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_logic_unit_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;

  logic_unit_if #(.WIDTH(WIDTH)) bus ();

  logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       zero;
    logic       parity;
  } vec_t;

  int          vectors;
  int          miscompares;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_y;
  logic [15:0] exp_ops;
  bit          accepted;

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      case (op)
        3'd0: r[i] = a[i] && b[i];
        3'd1: r[i] = a[i] || b[i];
        3'd2: r[i] = !a[i];
        3'd3: r[i] = !(a[i] && b[i]);
        3'd4: r[i] = !(a[i] || b[i]);
        3'd5: r[i] = a[i] != b[i];
        3'd6: r[i] = a[i] == b[i];
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic ref_parity(input logic [7:0] y);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (y[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] ey;
    ey = (exp_q.size() != 0) ? exp_q[0] : last_y;
    chk({tag, "_valid"},  32'(bus.out_valid),  32'(exp_q.size() != 0));
    chk({tag, "_ready"},  32'(bus.in_ready),   32'(exp_q.size() < DEPTH));
    chk({tag, "_y"},      32'(bus.out_y),      32'(ey));
    chk({tag, "_zero"},   32'(bus.out_zero),   32'(ey == 8'h00));
    chk({tag, "_parity"}, 32'(bus.out_parity), 32'(ref_parity(ey)));
    chk({tag, "_ops"},    32'(bus.ops_done),   32'(exp_ops));
  endtask

  // One clock of traffic; inputs applied now, model advanced and outputs checked after the edge.
  task automatic cycle(input string tag, input logic iv, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] op, input logic ordy);
    bit push;
    bit pop;
    logic [7:0] r;
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.out_ready = ordy;
    push = iv && (exp_q.size() < DEPTH);
    pop  = (exp_q.size() != 0) && ordy;
    r    = ref_op(a, b, op);
    @(posedge clk);
    #1;
    if (pop) begin
      last_y = exp_q.pop_front();
      if (exp_ops != 16'hFFFF) exp_ops = exp_ops + 16'd1;
    end
    if (push) exp_q.push_back(r);
    accepted = push;
    check_outputs(tag);
    $display("[%0t] %s: v=%0b a=%h b=%h op=%0d ordy=%0b -> out_v=%0b y=%h z=%0b p=%0b rdy=%0b ops=%0d",
             $time, tag, iv, a, b, op, ordy, bus.out_valid, bus.out_y, bus.out_zero,
             bus.out_parity, bus.in_ready, bus.ops_done);
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_y  = 8'h00;
    exp_ops = 16'h0000;
  endtask

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       cur_v;
    logic [7:0] cur_a;
    logic [7:0] cur_b;
    logic [2:0] cur_op;

    vectors     = 0;
    miscompares = 0;
    accepted    = 0;
    tbl[0] = '{8'hC3, 8'h5A, 3'd0, 8'h42, 1'b0, 1'b0};
    tbl[1] = '{8'hC3, 8'h5A, 3'd1, 8'hDB, 1'b0, 1'b0};
    tbl[2] = '{8'hC3, 8'h5A, 3'd2, 8'h3C, 1'b0, 1'b0};
    tbl[3] = '{8'hC3, 8'h5A, 3'd3, 8'hBD, 1'b0, 1'b0};
    tbl[4] = '{8'hC3, 8'h5A, 3'd4, 8'h24, 1'b0, 1'b0};
    tbl[5] = '{8'hC3, 8'h5A, 3'd5, 8'h99, 1'b0, 1'b0};
    tbl[6] = '{8'hC3, 8'h5A, 3'd6, 8'h66, 1'b0, 1'b0};
    tbl[7] = '{8'hC3, 8'h5A, 3'd7, 8'hC3, 1'b0, 1'b0};

    // Reset state
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_valid",  32'(bus.out_valid),  32'd0);
    chk("rst_y",      32'(bus.out_y),      32'd0);
    chk("rst_zero",   32'(bus.out_zero),   32'd0);
    chk("rst_parity", 32'(bus.out_parity), 32'd0);
    chk("rst_ops",    32'(bus.ops_done),   32'd0);
    #9;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed table: one accept per cycle, consumer always ready
    foreach (tbl[i]) begin
      cycle("t1", 1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1);
      chk("t1_tbl_y",      32'(bus.out_y),      32'(tbl[i].y));
      chk("t1_tbl_zero",   32'(bus.out_zero),   32'(tbl[i].zero));
      chk("t1_tbl_parity", 32'(bus.out_parity), 32'(tbl[i].parity));
    end
    cycle("t1_drain", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("t1_ops8", 32'(bus.ops_done), 32'd8);

    // Stalled consumer fills the buffer; held third push lands after a pop frees space
    cycle("t2_p1", 1'b1, 8'hFF, 8'hFF, 3'd5, 1'b0);
    cycle("t2_p2", 1'b1, 8'h01, 8'h00, 3'd1, 1'b0);
    chk("t2_full_ready", 32'(bus.in_ready),   32'd0);
    chk("t2_head_y",     32'(bus.out_y),      32'h00);
    chk("t2_head_zero",  32'(bus.out_zero),   32'd1);
    chk("t2_head_par",   32'(bus.out_parity), 32'd0);
    cycle("t2_ignored", 1'b1, 8'h55, 8'h00, 3'd7, 1'b0);
    chk("t2_ign_y", 32'(bus.out_y), 32'h00);
    cycle("t2_pop_full", 1'b1, 8'h55, 8'h00, 3'd7, 1'b1);
    chk("t2_pop1_y",     32'(bus.out_y),      32'h01);
    chk("t2_pop1_par",   32'(bus.out_parity), 32'd1);
    chk("t2_pop1_ready", 32'(bus.in_ready),   32'd1);
    cycle("t3_push_lands", 1'b1, 8'h55, 8'h00, 3'd7, 1'b1);
    chk("t3_order_y", 32'(bus.out_y), 32'h55);
    cycle("t3_drain", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("t3_hold_y",     32'(bus.out_y),     32'h55);
    chk("t3_empty_vld",  32'(bus.out_valid), 32'd0);

    // Steady-state push and pop at count 1 across pointer wraps
    for (int i = 0; i < 10; i++) begin
      cycle("t4", 1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b1);
    end
    cycle("t4_drain", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Randomized traffic; a refused transaction is held until accepted
    cur_v  = 1'b0;
    cur_a  = '0;
    cur_b  = '0;
    cur_op = '0;
    accepted = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!cur_v || accepted) begin
        cur_v  = ($urandom_range(0, 3) != 0);
        cur_a  = 8'($urandom);
        cur_b  = 8'($urandom);
        cur_op = 3'($urandom_range(0, 7));
      end
      cycle("rand", cur_v, cur_a, cur_b, cur_op, logic'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) cycle("rand_drain", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Asynchronous reset between edges with a full buffer
    cycle("t5_fill", 1'b1, 8'hA5, 8'h0F, 3'd0, 1'b0);
    cycle("t5_fill", 1'b1, 8'h3C, 8'hFF, 3'd5, 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_y",     32'(bus.out_y),     32'd0);
    chk("t5_rst_ops",   32'(bus.ops_done),  32'd0);
    #2;
    rst_n = 1'b1;
    cycle("t5_after", 1'b1, 8'h0F, 8'h00, 3'd2, 1'b1);
    chk("t5_nota_y", 32'(bus.out_y), 32'hF0);
    cycle("t5_drain", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // ops_done saturation from a preloaded value
    cycle("t6_fill", 1'b1, 8'h11, 8'h22, 3'd1, 1'b0);
    cycle("t6_fill", 1'b1, 8'h33, 8'h44, 3'd5, 1'b0);
    #2;
    force dut.r_ops_done = 16'hFFFE;
    #1;
    release dut.r_ops_done;
    exp_ops = 16'hFFFE;
    cycle("t6_pop1", 1'b1, 8'h77, 8'h00, 3'd7, 1'b1);
    chk("t6_ops_fff", 32'(bus.ops_done), 32'hFFFF);
    cycle("t6_pop2", 1'b1, 8'h77, 8'h00, 3'd7, 1'b1);
    cycle("t6_pop3", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("t6_ops_sat", 32'(bus.ops_done), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
